// File: rtl/alu_issue_if.sv
// Operand/opcode handshake bundle between the decode stage, the ID/EX issue
// register and the ALU, including the EX/MEM and MEM/WB forwarding taps.
interface alu_issue_if #(
    parameter int XLEN    = 32,
    parameter int REGADDR = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_class;
    logic [2:0]         in_funct3;
    logic               in_funct7b5;
    logic               in_use_imm;
    logic [REGADDR-1:0] in_rs1;
    logic [REGADDR-1:0] in_rs2;
    logic [XLEN-1:0]    in_rs1_val;
    logic [XLEN-1:0]    in_rs2_val;
    logic [XLEN-1:0]    in_imm;
    logic [REGADDR-1:0] in_rd;
    logic               exmem_wen;
    logic [REGADDR-1:0] exmem_rd;
    logic [XLEN-1:0]    exmem_val;
    logic               memwb_wen;
    logic [REGADDR-1:0] memwb_rd;
    logic [XLEN-1:0]    memwb_val;
    logic               flush;
    logic               out_ready;
    logic               out_valid;
    logic [XLEN-1:0]    data1;
    logic [XLEN-1:0]    data2;
    logic [3:0]         aluoperation;
    logic [REGADDR-1:0] out_rd;
    logic               illegal;

    modport master (
        output in_valid, in_class, in_funct3, in_funct7b5, in_use_imm,
               in_rs1, in_rs2, in_rs1_val, in_rs2_val, in_imm, in_rd,
               exmem_wen, exmem_rd, exmem_val, memwb_wen, memwb_rd, memwb_val,
               flush, out_ready,
        input  in_ready, out_valid, data1, data2, aluoperation, out_rd, illegal
    );

    modport slave (
        input  in_valid, in_class, in_funct3, in_funct7b5, in_use_imm,
               in_rs1, in_rs2, in_rs1_val, in_rs2_val, in_imm, in_rd,
               exmem_wen, exmem_rd, exmem_val, memwb_wen, memwb_rd, memwb_val,
               flush, out_ready,
        output in_ready, out_valid, data1, data2, aluoperation, out_rd, illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes the ALU opcode, selects and forwards operands,
// and holds one instruction under a valid/ready handshake with stall and flush.
module alu_issue_stage #(
    parameter int XLEN    = 32,
    parameter int REGADDR = 5
) (
    input  logic        clk,
    input  logic        reset,
    alu_issue_if.slave  bus
);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_BAD = 4'b1111;

    function automatic logic [3:0] decode_op(
        input logic [1:0] cls,
        input logic [2:0] f3,
        input logic       f7b5
    );
        logic [3:0] op;
        op = OP_BAD;
        case (cls)
            2'b10:   op = OP_ADD;
            2'b11:   op = OP_SUB;
            default: begin
                case (f3)
                    3'b000:  op = ((cls == 2'b00) && f7b5) ? OP_SUB : OP_ADD;
                    3'b100:  op = OP_XOR;
                    3'b110:  op = OP_OR;
                    3'b111:  op = OP_AND;
                    default: op = OP_BAD;
                endcase
            end
        endcase
        return op;
    endfunction

    // Youngest in-flight writer wins; x0 is never a forwarding target.
    function automatic logic [XLEN-1:0] fwd(
        input logic [REGADDR-1:0] rs,
        input logic [XLEN-1:0]    base,
        input logic               ex_wen,
        input logic [REGADDR-1:0] ex_rd,
        input logic [XLEN-1:0]    ex_val,
        input logic               wb_wen,
        input logic [REGADDR-1:0] wb_rd,
        input logic [XLEN-1:0]    wb_val
    );
        logic [XLEN-1:0] v;
        v = base;
        if (rs == '0) begin
            v = base;
        end else if (ex_wen && (ex_rd == rs)) begin
            v = ex_val;
        end else if (wb_wen && (wb_rd == rs)) begin
            v = wb_val;
        end else begin
            v = base;
        end
        return v;
    endfunction

    logic               valid_q,   valid_d;
    logic [XLEN-1:0]    data1_q,   data1_d;
    logic [XLEN-1:0]    data2_q,   data2_d;
    logic [3:0]         aluop_q,   aluop_d;
    logic [REGADDR-1:0] rd_q,      rd_d;
    logic               illegal_q, illegal_d;
    logic [REGADDR-1:0] rs1_q,     rs1_d;
    logic [REGADDR-1:0] rs2_q,     rs2_d;
    logic               imm_sel_q, imm_sel_d;
    logic               in_ready_s;
    logic               accept_s;
    logic [3:0]         dec_op_s;

    assign in_ready_s = reset | ~valid_q | bus.out_ready;
    assign accept_s   = bus.in_valid & in_ready_s & ~bus.flush;
    assign dec_op_s   = decode_op(bus.in_class, bus.in_funct3, bus.in_funct7b5);

    // Next-state: flush, then accept, then consume, then stall-time refresh.
    always_comb begin
        valid_d   = valid_q;
        data1_d   = data1_q;
        data2_d   = data2_q;
        aluop_d   = aluop_q;
        rd_d      = rd_q;
        illegal_d = illegal_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        imm_sel_d = imm_sel_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (accept_s) begin
            valid_d   = 1'b1;
            aluop_d   = dec_op_s;
            illegal_d = (dec_op_s == OP_BAD);
            rd_d      = bus.in_rd;
            rs1_d     = bus.in_rs1;
            rs2_d     = bus.in_rs2;
            imm_sel_d = bus.in_use_imm;
            data1_d   = fwd(bus.in_rs1, bus.in_rs1_val,
                            bus.exmem_wen, bus.exmem_rd, bus.exmem_val,
                            bus.memwb_wen, bus.memwb_rd, bus.memwb_val);
            if (bus.in_use_imm) begin
                data2_d = bus.in_imm;
            end else begin
                data2_d = fwd(bus.in_rs2, bus.in_rs2_val,
                              bus.exmem_wen, bus.exmem_rd, bus.exmem_val,
                              bus.memwb_wen, bus.memwb_rd, bus.memwb_val);
            end
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            // Held entry: pick up results that were still in flight at issue.
            data1_d = fwd(rs1_q, data1_q,
                          bus.exmem_wen, bus.exmem_rd, bus.exmem_val,
                          bus.memwb_wen, bus.memwb_rd, bus.memwb_val);
            if (imm_sel_q) begin
                data2_d = data2_q;
            end else begin
                data2_d = fwd(rs2_q, data2_q,
                              bus.exmem_wen, bus.exmem_rd, bus.exmem_val,
                              bus.memwb_wen, bus.memwb_rd, bus.memwb_val);
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // Issue register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            data1_q   <= '0;
            data2_q   <= '0;
            aluop_q   <= OP_ADD;
            rd_q      <= '0;
            illegal_q <= 1'b0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_sel_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            data1_q   <= data1_d;
            data2_q   <= data2_d;
            aluop_q   <= aluop_d;
            rd_q      <= rd_d;
            illegal_q <= illegal_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            imm_sel_q <= imm_sel_d;
        end
    end

    assign bus.in_ready     = in_ready_s;
    assign bus.out_valid    = valid_q;
    assign bus.data1        = data1_q;
    assign bus.data2        = data2_q;
    assign bus.aluoperation = aluop_q;
    assign bus.out_rd       = rd_q;
    assign bus.illegal      = illegal_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus randomized
// traffic compared every cycle against a behavioural model of the stage.
module tb_alu_issue_stage;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    alu_issue_if #(.XLEN(32), .REGADDR(5)) bus ();

    alu_issue_stage #(.XLEN(32), .REGADDR(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: the instruction currently presented to the ALU, if any.
    bit          m_valid;
    logic [31:0] m_d1, m_d2;
    logic [3:0]  m_op;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    bit          m_ill, m_imm;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_op(input logic [1:0] cls, input logic [2:0] f3, input logic f7);
        if (cls == 2'd2) return 4'd0;
        if (cls == 2'd3) return 4'd1;
        if (f3 == 3'd0)  return (cls == 2'd0 && f7) ? 4'd1 : 4'd0;
        if (f3 == 3'd4)  return 4'd4;
        if (f3 == 3'd6)  return 4'd3;
        if (f3 == 3'd7)  return 4'd2;
        return 4'd15;
    endfunction

    // Value register rs holds as seen by an instruction now, given fallback.
    function automatic logic [31:0] model_src(input logic [4:0] rs, input logic [31:0] fallback);
        if (rs == 5'd0) return fallback;
        if (bus.exmem_wen && bus.exmem_rd == rs) return bus.exmem_val;
        if (bus.memwb_wen && bus.memwb_rd == rs) return bus.memwb_val;
        return fallback;
    endfunction

    task automatic model_update();
        bit rdy;
        rdy = reset || !m_valid || bus.out_ready;
        if (reset) begin
            m_valid = 1'b0; m_d1 = 32'd0; m_d2 = 32'd0; m_op = 4'd0;
            m_rd = 5'd0; m_ill = 1'b0; m_rs1 = 5'd0; m_rs2 = 5'd0; m_imm = 1'b0;
        end else if (bus.flush) begin
            m_valid = 1'b0;
        end else if (bus.in_valid && rdy) begin
            m_valid = 1'b1;
            m_op    = model_op(bus.in_class, bus.in_funct3, bus.in_funct7b5);
            m_ill   = (m_op == 4'd15);
            m_rd    = bus.in_rd;
            m_rs1   = bus.in_rs1;
            m_rs2   = bus.in_rs2;
            m_imm   = bus.in_use_imm;
            m_d1    = model_src(bus.in_rs1, bus.in_rs1_val);
            m_d2    = bus.in_use_imm ? bus.in_imm : model_src(bus.in_rs2, bus.in_rs2_val);
        end else if (m_valid && bus.out_ready) begin
            m_valid = 1'b0;
        end else if (m_valid) begin
            m_d1 = model_src(m_rs1, m_d1);
            if (!m_imm) m_d2 = model_src(m_rs2, m_d2);
        end
    endtask

    // One clock: check in_ready against current inputs, advance model, check outputs.
    task automatic step();
        #2;
        check("in_ready", {31'd0, bus.in_ready}, {31'd0, (reset || !m_valid || bus.out_ready)});
        model_update();
        @(posedge clk);
        #1;
        check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
        if (m_valid) begin
            check("data1", bus.data1, m_d1);
            check("data2", bus.data2, m_d2);
            check("aluop", {28'd0, bus.aluoperation}, {28'd0, m_op});
            check("out_rd", {27'd0, bus.out_rd}, {27'd0, m_rd});
            check("illegal", {31'd0, bus.illegal}, {31'd0, m_ill});
        end
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0; bus.in_class = 2'd0; bus.in_funct3 = 3'd0;
        bus.in_funct7b5 = 1'b0; bus.in_use_imm = 1'b0; bus.in_rs1 = 5'd0;
        bus.in_rs2 = 5'd0; bus.in_rs1_val = 32'd0; bus.in_rs2_val = 32'd0;
        bus.in_imm = 32'd0; bus.in_rd = 5'd0; bus.exmem_wen = 1'b0;
        bus.exmem_rd = 5'd0; bus.exmem_val = 32'd0; bus.memwb_wen = 1'b0;
        bus.memwb_rd = 5'd0; bus.memwb_val = 32'd0; bus.flush = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_valid = 1'b0; m_d1 = 32'd0; m_d2 = 32'd0; m_op = 4'd0; m_rd = 5'd0;
        m_rs1 = 5'd0; m_rs2 = 5'd0; m_ill = 1'b0; m_imm = 1'b0;
        reset = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        step();
        reset = 1'b0;

        // Reset while an entry is stalled.
        bus.in_valid = 1'b1; bus.in_rs1_val = 32'd11; bus.in_rs2_val = 32'd12; bus.in_rd = 5'd3;
        step();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_data1", bus.data1, 32'd0);
        check("rst_data2", bus.data2, 32'd0);
        check("rst_aluop", {28'd0, bus.aluoperation}, 32'd0);
        check("rst_ready", {31'd0, bus.in_ready}, 32'd1);

        // R-type SUB, no forwarding.
        bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.in_class = 2'd0; bus.in_funct3 = 3'd0;
        bus.in_funct7b5 = 1'b1; bus.in_rs1 = 5'd1; bus.in_rs2 = 5'd2;
        bus.in_rs1_val = 32'd50; bus.in_rs2_val = 32'd30; bus.in_rd = 5'd4;
        step();
        check("sub_valid", {31'd0, bus.out_valid}, 32'd1);
        check("sub_data1", bus.data1, 32'd50);
        check("sub_data2", bus.data2, 32'd30);
        check("sub_aluop", {28'd0, bus.aluoperation}, 32'd1);

        // I-type XOR, EX/MEM beats MEM/WB, immediate operand.
        bus.in_class = 2'd1; bus.in_funct3 = 3'd4; bus.in_funct7b5 = 1'b0; bus.in_rs1 = 5'd5;
        bus.in_rs1_val = 32'd1; bus.exmem_wen = 1'b1; bus.exmem_rd = 5'd5; bus.exmem_val = 32'd7;
        bus.memwb_wen = 1'b1; bus.memwb_rd = 5'd5; bus.memwb_val = 32'd9;
        bus.in_use_imm = 1'b1; bus.in_imm = 32'd2;
        step();
        check("xor_data1", bus.data1, 32'd7);
        check("xor_data2", bus.data2, 32'd2);
        check("xor_aluop", {28'd0, bus.aluoperation}, 32'd4);

        // Stall with MEM/WB refresh of rs2.
        bus.exmem_wen = 1'b0; bus.memwb_wen = 1'b0; bus.in_use_imm = 1'b0;
        bus.in_class = 2'd0; bus.in_funct3 = 3'd7; bus.in_rs1 = 5'd1; bus.in_rs2 = 5'd8;
        bus.in_rs2_val = 32'd3;
        step();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        step();
        check("stall_ready", {31'd0, bus.in_ready}, 32'd0);
        check("stall_d2_a", bus.data2, 32'd3);
        bus.memwb_wen = 1'b1; bus.memwb_rd = 5'd8; bus.memwb_val = 32'd6;
        step();
        bus.memwb_wen = 1'b0;
        step();
        check("stall_d2_b", bus.data2, 32'd6);
        check("stall_aluop", {28'd0, bus.aluoperation}, 32'd2);
        check("stall_ready2", {31'd0, bus.in_ready}, 32'd0);

        // Flush while holding, then x0 never forwarded.
        bus.in_valid = 1'b1; bus.flush = 1'b1;
        step();
        check("flush_valid", {31'd0, bus.out_valid}, 32'd0);
        bus.flush = 1'b0; bus.out_ready = 1'b1; bus.in_rs1 = 5'd0; bus.in_rs1_val = 32'd0;
        bus.exmem_wen = 1'b1; bus.exmem_rd = 5'd0; bus.exmem_val = 32'd99;
        step();
        check("x0_data1", bus.data1, 32'd0);
        bus.exmem_wen = 1'b0;

        // Unsupported funct3, then four back-to-back instructions.
        bus.in_class = 2'd0; bus.in_funct3 = 3'd1;
        step();
        check("ill_aluop", {28'd0, bus.aluoperation}, 32'd15);
        check("ill_flag", {31'd0, bus.illegal}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            bus.in_funct3 = 3'd6; bus.in_rd = 5'(10 + k); bus.in_rs1_val = 32'(100 + k);
            step();
            check("b2b_valid", {31'd0, bus.out_valid}, 32'd1);
            check("b2b_rd", {27'd0, bus.out_rd}, 32'(10 + k));
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            reset            = ($urandom_range(0, 99) == 0);
            bus.flush        = ($urandom_range(0, 19) == 0);
            bus.in_valid     = ($urandom_range(0, 9) < 7);
            bus.out_ready    = ($urandom_range(0, 9) < 6);
            bus.in_class     = 2'($urandom);
            bus.in_funct3    = 3'($urandom);
            bus.in_funct7b5  = 1'($urandom);
            bus.in_use_imm   = 1'($urandom);
            bus.in_rs1       = 5'($urandom_range(0, 3));
            bus.in_rs2       = 5'($urandom_range(0, 3));
            bus.in_rs1_val   = $urandom;
            bus.in_rs2_val   = $urandom;
            bus.in_imm       = $urandom;
            bus.in_rd        = 5'($urandom);
            bus.exmem_wen    = 1'($urandom);
            bus.exmem_rd     = 5'($urandom_range(0, 3));
            bus.exmem_val    = $urandom;
            bus.memwb_wen    = 1'($urandom);
            bus.memwb_rd     = 5'($urandom_range(0, 3));
            bus.memwb_val    = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
